// File: rtl/mont_modexp_rt.sv
// rtl/mont_modexp_rt.sv - runtime-modulus Montgomery modular exponentiator
// One shared combinational REDC unit, time-multiplexed by the FSM, with valid/ready on both sides.
module mont_modexp_rt #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mod_in,
    input  logic [WIDTH-1:0]     nprime_in,
    input  logic [WIDTH-1:0]     r2_in,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exp_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_CONV_B,
        S_CONV_1,
        S_MUL,
        S_SQR,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_nprime;
    logic [WIDTH-1:0]     r_r2;
    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_res;
    logic [EXP_WIDTH-1:0] r_exp;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_err;

    logic [WIDTH-1:0]     w_op_a;
    logic [WIDTH-1:0]     w_op_b;
    logic [2*WIDTH-1:0]   w_t;
    logic [WIDTH-1:0]     w_m;
    logic [2*WIDTH-1:0]   w_mm;
    logic [WIDTH:0]       w_tr;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_redc;
    logic                 w_bad_mod;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err       = r_err;

    // Operand mux: each state owns the REDC unit for its single cycle.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_CONV_B: begin w_op_a = r_base; w_op_b = r_r2;   end
            S_CONV_1: begin w_op_a = ONE;    w_op_b = r_r2;   end
            S_MUL:    begin w_op_a = r_res;  w_op_b = r_base; end
            S_SQR:    begin w_op_a = r_base; w_op_b = r_base; end
            S_OUT:    begin w_op_a = r_res;  w_op_b = ONE;    end
            default:  begin w_op_a = '0;     w_op_b = '0;     end
        endcase
    end

    assign w_t    = {{WIDTH{1'b0}}, w_op_a} * {{WIDTH{1'b0}}, w_op_b};
    assign w_m    = w_t[WIDTH-1:0] * r_nprime;
    assign w_mm   = {{WIDTH{1'b0}}, w_m} * {{WIDTH{1'b0}}, r_mod};
    // Low WIDTH bits of T + m*M are zero by construction; keep the carry-extended top half.
    assign w_tr   = (WIDTH+1)'(({1'b0, w_t} + {1'b0, w_mm}) >> WIDTH);
    assign w_ge   = w_tr >= {1'b0, r_mod};
    assign w_redc = WIDTH'(w_ge ? (w_tr - {1'b0, r_mod}) : w_tr);

    assign w_bad_mod = !mod_in[0] || (mod_in < WIDTH'(3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mod       <= '0;
            r_nprime    <= '0;
            r_r2        <= '0;
            r_base      <= '0;
            r_res       <= '0;
            r_exp       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mod      <= mod_in;
                        r_nprime   <= nprime_in;
                        r_r2       <= r2_in;
                        r_base     <= base_in;
                        r_exp      <= exp_in;
                        r_in_ready <= 1'b0;
                        r_state    <= w_bad_mod ? S_ERR : S_CONV_B;
                    end
                end
                S_ERR: begin
                    r_result    <= '0;
                    r_err       <= 1'b1;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_CONV_B: begin
                    r_base  <= w_redc;
                    r_state <= S_CONV_1;
                end
                S_CONV_1: begin
                    r_res <= w_redc;
                    if (r_exp == '0)
                        r_state <= S_OUT;
                    else if (r_exp[0])
                        r_state <= S_MUL;
                    else
                        r_state <= S_SQR;
                end
                S_MUL: begin
                    r_res   <= w_redc;
                    r_state <= (r_exp == EXP_WIDTH'(1)) ? S_OUT : S_SQR;
                end
                S_SQR: begin
                    // Entered only with r_exp >= 2, so the shifted exponent stays nonzero.
                    r_base  <= w_redc;
                    r_exp   <= r_exp >> 1;
                    r_state <= r_exp[1] ? S_MUL : S_SQR;
                end
                S_OUT: begin
                    r_result    <= w_redc;
                    r_err       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_rt.sv
// tb/tb_mont_modexp_rt.sv - scoreboard bench for mont_modexp_rt (32-bit and 8-bit instances)
module tb_mont_modexp_rt;

    typedef struct {
        logic [31:0] res;
        logic        erf;
        int          lat;
        int          acc;
    } entry_t;

    localparam logic [31:0] M  = 32'd998244353;
    localparam logic [31:0] NP = 32'd998244351;
    localparam logic [31:0] R2 = 32'd932051910;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        iv32, ir32, ov32, ordy32, err32;
    logic [31:0] mod32, np32, r232, b32, e32, res32;
    logic        iv8, ir8, ov8, ordy8, err8;
    logic [7:0]  mod8, np8, r28, b8, e8, res8;

    entry_t q32[$];
    entry_t q8[$];
    bit     prev_ov[2];

    mont_modexp_rt #(.WIDTH(32), .EXP_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .mod_in(mod32), .nprime_in(np32), .r2_in(r232), .base_in(b32), .exp_in(e32),
        .out_valid(ov32), .out_ready(ordy32), .result(res32), .err(err32)
    );

    mont_modexp_rt #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .mod_in(mod8), .nprime_in(np8), .r2_in(r28), .base_in(b8), .exp_in(e8),
        .out_valid(ov8), .out_ready(ordy8), .result(res8), .err(err8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
        logic [63:0] r, bb, ee;
        r = 1; bb = b % m; ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return r % m;
    endfunction

    function automatic int lat_of(input logic [31:0] e);
        int msb;
        if (e == 0) return 3;
        msb = 0;
        for (int i = 0; i < 32; i++) if (e[i]) msb = i;
        return 3 + $countones(e) + msb;
    endfunction

    task automatic mon(input int id, input logic ov, input logic ordy, input logic [31:0] res, input logic ef);
        entry_t e;
        bit     have;
        if (rst) begin prev_ov[id] = 1'b0; return; end
        have = (id == 0) ? (q32.size() != 0) : (q8.size() != 0);
        if (ov) begin
            if (!have) begin
                checks++; errors++;
                $display("FAIL unexpected_output dut%0d actual=%0d expected=none", id, res);
            end else begin
                e = (id == 0) ? q32[0] : q8[0];
                if (!prev_ov[id]) chk(id == 0 ? "latency32" : "latency8", 64'(cyc - e.acc), 64'(e.lat));
                chk(id == 0 ? "result32" : "result8", {32'd0, res}, {32'd0, e.res});
                chk(id == 0 ? "err32" : "err8", {63'd0, ef}, {63'd0, e.erf});
                if (ordy) begin
                    if (id == 0) void'(q32.pop_front());
                    else         void'(q8.pop_front());
                end
            end
        end
        prev_ov[id] = ov;
    endtask

    always begin
        @(negedge clk);
        #2;
        mon(0, ov32, ordy32, res32, err32);
        mon(1, ov8, ordy8, {24'd0, res8}, err8);
    end

    task automatic issue32(input logic [31:0] m, np, r2, b, e, input logic [31:0] er, input logic ee,
                           input int lat, input bit push);
        int n;
        entry_t t;
        @(negedge clk);
        iv32 = 1'b1; mod32 = m; np32 = np; r232 = r2; b32 = b; e32 = e;
        n = 0;
        while (!ir32 && n < 2000) begin @(negedge clk); n++; end
        if (!ir32) begin
            checks++; errors++;
            $display("FAIL accept_timeout32 actual=0 expected=1");
            iv32 = 1'b0;
            return;
        end
        t.res = er; t.erf = ee; t.lat = lat; t.acc = cyc + 1;
        if (push) q32.push_back(t);
        @(negedge clk);
        iv32 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] b, e, input logic [7:0] er, input int lat);
        int n;
        entry_t t;
        @(negedge clk);
        iv8 = 1'b1; mod8 = 8'd13; np8 = 8'd59; r28 = 8'd3; b8 = b; e8 = e;
        n = 0;
        while (!ir8 && n < 2000) begin @(negedge clk); n++; end
        if (!ir8) begin
            checks++; errors++;
            $display("FAIL accept_timeout8 actual=0 expected=1");
            iv8 = 1'b0;
            return;
        end
        t.res = {24'd0, er}; t.erf = 1'b0; t.lat = lat; t.acc = cyc + 1;
        q8.push_back(t);
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 5000) begin @(negedge clk); n++; end
        if (q32.size() != 0 || q8.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", q32.size() + q8.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int exps[8] = '{0, 1, 2, 3, 5, 12, 128, 255};
        rst = 1'b1;
        iv32 = 0; ordy32 = 1; mod32 = 0; np32 = 0; r232 = 0; b32 = 0; e32 = 0;
        iv8 = 0; ordy8 = 1; mod8 = 0; np8 = 0; r28 = 0; b8 = 0; e8 = 0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {63'd0, ir32}, 64'd1);
        chk("reset_out_valid", {63'd0, ov32}, 64'd0);
        chk("reset_result", {32'd0, res32}, 64'd0);
        chk("reset_err", {63'd0, err32}, 64'd0);
        rst = 1'b0;

        issue32(M, NP, R2, 32'd3, 32'd5, 32'd243, 1'b0, 7, 1'b1);
        issue32(M, NP, R2, 32'd2, 32'd998244352, 32'd1, 1'b0, 38, 1'b1);
        issue32(M, NP, R2, 32'd0, 32'd0, 32'd1, 1'b0, 3, 1'b1);
        issue8(8'd7, 8'd12, 8'd1, 8);
        issue8(8'd20, 8'd2, 8'd10, 5);

        issue32(32'd998244352, NP, R2, 32'd3, 32'd5, 32'd0, 1'b1, 1, 1'b1);
        issue32(32'd1, NP, R2, 32'd3, 32'd5, 32'd0, 1'b1, 1, 1'b1);
        issue32(M, NP, R2, 32'd3, 32'd5, 32'd243, 1'b0, 7, 1'b1);
        drain();

        // Backpressure: output held, extra requests ignored.
        ordy32 = 1'b0;
        issue32(M, NP, R2, 32'd3, 32'd5, 32'd243, 1'b0, 7, 1'b1);
        n = 0;
        while (!ov32 && n < 100) begin @(negedge clk); n++; end
        chk("stall_out_valid_seen", {63'd0, ov32}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, ir32}, 64'd0);
            chk("stall_out_valid", {63'd0, ov32}, 64'd1);
            iv32 = i[0]; mod32 = M; np32 = NP; r232 = R2; b32 = 32'd2; e32 = 32'd3;
        end
        iv32 = 1'b0;
        ordy32 = 1'b1;
        @(negedge clk);
        chk("post_transfer_in_ready", {63'd0, ir32}, 64'd1);
        chk("post_transfer_out_valid", {63'd0, ov32}, 64'd0);
        issue32(M, NP, R2, 32'd3, 32'd5, 32'd243, 1'b0, 7, 1'b1);
        drain();

        // Abort a long job while it is squaring.
        issue32(M, NP, R2, 32'd2, 32'd998244352, 32'd0, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {63'd0, ir32}, 64'd1);
        chk("abort_out_valid", {63'd0, ov32}, 64'd0);
        chk("abort_result", {32'd0, res32}, 64'd0);
        rst = 1'b0;
        issue32(M, NP, R2, 32'd3, 32'd5, 32'd243, 1'b0, 7, 1'b1);
        drain();

        for (int b = 0; b < 256; b++) begin
            for (int k = 0; k < 8; k++) begin
                issue8(8'(b), 8'(exps[k]), 8'(modexp(64'(b), 64'(exps[k]), 64'd13)), lat_of(32'(exps[k])));
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
